// File: rtl/alu_pkg.sv
// Shared encodings for the RV32IM execute unit: funct3/funct7 decode constants
// and the sequencing state type.
package alu_pkg;

   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_XOR    = 3'b100;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/alu_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle on magnitudes, with
// sign fix-up and the RISC-V divide-by-zero / overflow results.
module alu_divider
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] quo, rem, dvs, dvd_orig;
   logic        neg_q, neg_r, div_zero, ovf, busy;
   logic [4:0]  count;
   logic [32:0] shifted;
   logic [33:0] trial;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

   assign shifted = {rem, quo[31]};
   assign trial   = {1'b0, shifted} - {2'b00, dvs};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         done  <= 1'b0;
         count <= '0;
      end else if (busy) begin
         count <= count + 5'd1;
         if (count == 5'd31) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   // a negative trial keeps the shifted remainder (restore) and shifts in a 0
   always_ff @(posedge clk) begin
      if (start) begin
         quo      <= magnitude(dividend, is_signed);
         dvs      <= magnitude(divisor, is_signed);
         rem      <= '0;
         dvd_orig <= dividend;
         neg_q    <= is_signed && (dividend[31] ^ divisor[31]);
         neg_r    <= is_signed && dividend[31];
         div_zero <= (divisor == '0);
         ovf      <= is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
      end else if (busy) begin
         rem <= trial[33] ? shifted[31:0] : trial[31:0];
         quo <= {quo[30:0], ~trial[33]};
      end
   end

   assign quotient  = div_zero ? 32'hFFFF_FFFF :
                      ovf      ? 32'h8000_0000 :
                      neg_q    ? -quo : quo;
   assign remainder = div_zero ? dvd_orig :
                      ovf      ? 32'h0000_0000 :
                      neg_r    ? -rem : rem;

endmodule

// File: rtl/alu.sv
// RV32IM execute unit: base ops answer in the ready cycle, MUL family after one
// cycle from a registered product, DIV/REM family after 33 cycles.
module alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        is_imm,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   output logic [31:0] out,
   output logic        done
);

   state_t             state, state_next;
   logic               is_m, op_mul, mul_low, div_rem, finish, div_done;
   logic [31:0]        base_res, m_res, result, quotient, remainder;
   logic signed [32:0] mul_a, mul_b;
   logic [63:0]        product_full, product_p1;

   assign is_m = !is_imm && (funct7 == FUNCT7_MULDIV);

   always_comb begin
      base_res = '0;
      case (funct3)
         F3_ADD:  base_res = (!is_imm && funct7[5]) ? in1 - in2 : in1 + in2;
         F3_SLL:  base_res = in1 << in2[4:0];
         F3_SLT:  base_res = {31'b0, $signed(in1) < $signed(in2)};
         F3_SLTU: base_res = {31'b0, in1 < in2};
         F3_XOR:  base_res = in1 ^ in2;
         F3_SR:   base_res = funct7[5] ? 32'($signed(in1) >>> in2[4:0]) : in1 >> in2[4:0];
         F3_OR:   base_res = in1 | in2;
         default: base_res = in1 & in2;
      endcase
   end

   // 33-bit operands let one signed multiplier cover MULH, MULHSU and MULHU
   assign mul_a        = {((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) && in1[31], in1};
   assign mul_b        = {(funct3 == F3_MULH) && in2[31], in2};
   assign product_full = 64'(mul_a) * 64'(mul_b);

   always_ff @(posedge clk) begin
      if (ready && is_m && !funct3[2])
         product_p1 <= product_full;
   end

   alu_divider u_divider (
      .clk       (clk),
      .rst       (rst),
      .start     (ready && is_m && funct3[2]),
      .is_signed (!funct3[0]),
      .dividend  (in1),
      .divisor   (in2),
      .done      (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   assign finish = op_mul || div_done;
   assign m_res  = op_mul  ? (mul_low ? product_p1[31:0] : product_p1[63:32]) :
                   div_rem ? remainder : quotient;

   always_comb begin
      state_next = state;
      if (ready)
         state_next = is_m ? BUSY : DONE;
      else begin
         case (state)
            BUSY:    if (finish) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         result  <= '0;
         op_mul  <= 1'b0;
         mul_low <= 1'b0;
         div_rem <= 1'b0;
      end else begin
         state <= state_next;
         if (ready && is_m) begin
            op_mul  <= !funct3[2];
            mul_low <= (funct3[1:0] == 2'b00);
            div_rem <= funct3[1];
         end
         if (ready && !is_m)
            result <= base_res;
         else if (!ready && state == BUSY && finish)
            result <= m_res;
      end
   end

   // a new ready always overrides whatever the registered path would show
   always_comb begin
      out  = result;
      done = 1'b0;
      if (ready) begin
         done = !is_m;
         out  = is_m ? result : base_res;
      end else if (state == DONE) begin
         done = 1'b1;
      end else if (state == BUSY) begin
         done = finish;
         out  = m_res;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the RV32IM execute unit against an
// arithmetic reference model with a per-class latency table.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst, ready, is_imm, done;
   logic [31:0] in1, in2, out;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   alu dut (
      .clk    (clk),
      .rst    (rst),
      .ready  (ready),
      .in1    (in1),
      .in2    (in2),
      .is_imm (is_imm),
      .funct3 (funct3),
      .funct7 (funct7),
      .out    (out),
      .done   (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic imm, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p, ua64, ub64;
      int          ia, ib;
      logic        ovf;
      sa   = longint'(signed'(a));
      sb   = longint'(signed'(b));
      ub   = longint'({32'b0, b});
      ua64 = {32'b0, a};
      ub64 = {32'b0, b};
      ia   = a;
      ib   = b;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (!imm && f7 == 7'b0000001) begin
         case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
         endcase
      end
      case (f3)
         3'd0: return (!imm && f7[5]) ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return (ia < ib) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return f7[5] ? 32'(ia >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f3, input logic [6:0] f7, input logic imm);
      if (imm || f7 != 7'b0000001) return 0;
      return f3[2] ? 33 : 1;
   endfunction

   task automatic scramble();
      in1    = $urandom;
      in2    = $urandom;
      funct3 = 3'($urandom);
      funct7 = 7'($urandom);
      is_imm = 1'($urandom);
   endtask

   task automatic start_raw(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                            input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in1 = a; in2 = b; funct3 = f3; funct7 = f7; is_imm = imm; ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      scramble();
   endtask

   task automatic run(input string tag, input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                      input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int          lat;
      exp = model(f3, f7, imm, a, b);
      lat = latency(f3, f7, imm);
      @(negedge clk);
      in1 = a; in2 = b; funct3 = f3; funct7 = f7; is_imm = imm; ready = 1'b1;
      #1;
      if (lat == 0) begin
         chk({tag, " done@0"}, {31'b0, done}, 32'd1);
         chk({tag, " out@0"}, out, exp);
      end else begin
         chk({tag, " done@0"}, {31'b0, done}, 32'd0);
      end
      @(negedge clk);
      ready = 1'b0;
      scramble();
      #1;
      for (int k = 1; k < lat; k++) begin
         chk({tag, " busy"}, {31'b0, done}, 32'd0);
         @(negedge clk);
         #1;
      end
      chk({tag, " done"}, {31'b0, done}, 32'd1);
      chk({tag, " out"}, out, exp);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         #1;
         chk({tag, " hold done"}, {31'b0, done}, 32'd1);
         chk({tag, " hold out"}, out, exp);
      end
   endtask

   initial begin
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        imm;
      logic [31:0] a, b;

      rst = 1'b1; ready = 1'b0; in1 = '0; in2 = '0; funct3 = '0; funct7 = '0; is_imm = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset out", out, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("idle done", {31'b0, done}, 32'd0);
      chk("idle out", out, 32'd0);

      run("sub",    3'b000, 7'b0100000, 1'b0, 32'd5, 32'd3, 0);
      run("addi",   3'b000, 7'b0100000, 1'b1, 32'd5, 32'd3, 0);
      run("sra",    3'b101, 7'b0100000, 1'b0, 32'h8000_0000, 32'd4, 0);
      run("srl",    3'b101, 7'b0000000, 1'b0, 32'h8000_0000, 32'd4, 0);
      run("srai",   3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 32'd4, 0);
      run("slt",    3'b010, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 32'd1, 5);
      run("sltu",   3'b011, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 32'd1, 5);
      run("mulh",   3'b001, 7'b0000001, 1'b0, 32'h8000_0000, 32'd2, 2);
      run("mulhu",  3'b011, 7'b0000001, 1'b0, 32'h8000_0000, 32'd2, 0);
      run("mulhsu", 3'b010, 7'b0000001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run("mul",    3'b000, 7'b0000001, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      run("div",    3'b100, 7'b0000001, 1'b0, 32'hFFFF_FFF9, 32'd2, 3);
      run("rem",    3'b110, 7'b0000001, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
      run("divu0",  3'b101, 7'b0000001, 1'b0, 32'hDEAD_BEEF, 32'd0, 0);
      run("remu0",  3'b111, 7'b0000001, 1'b0, 32'hDEAD_BEEF, 32'd0, 0);
      run("div0",   3'b100, 7'b0000001, 1'b0, 32'h0000_0007, 32'd0, 0);
      run("divovf", 3'b100, 7'b0000001, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run("removf", 3'b110, 7'b0000001, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

      // asynchronous reset in the middle of a divide
      start_raw(3'b100, 7'b0000001, 1'b0, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst mid-div done", {31'b0, done}, 32'd0);
      chk("rst mid-div out", out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         #1;
         chk("after rst idle", {31'b0, done}, 32'd0);
      end

      // restart mid-divide, then restart exactly in the completion cycle
      start_raw(3'b100, 7'b0000001, 1'b0, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      run("restart divu", 3'b101, 7'b0000001, 1'b0, 32'd1000, 32'd10, 0);
      start_raw(3'b100, 7'b0000001, 1'b0, 32'd1000, 32'd7);
      repeat (31) @(negedge clk);
      #1;
      chk("pre-complete", {31'b0, done}, 32'd0);
      run("restart at end", 3'b110, 7'b0000001, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
      start_raw(3'b100, 7'b0000001, 1'b0, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      run("base aborts div", 3'b100, 7'b0000000, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 40);

      for (int i = 0; i < 80; i++) begin
         f3  = 3'($urandom);
         imm = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       f7 = 7'b0000000;
            1:       f7 = 7'b0100000;
            2:       f7 = 7'b0000001;
            default: f7 = 7'($urandom);
         endcase
         a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 40));
            default: b = $urandom;
         endcase
         run("random", f3, f7, imm, a, b, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
